// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Owns the program counter, reads instruction words through BRAM port A, which has a
// 1-cycle synchronous read. Fetched words go to decode over a valid/ready handshake.
// A redirect flushes everything fetched so far and restarts fetch at a new PC.
//
// Optional feature macro: FETCH_PREFETCH_EN
//   undefined : 3-state FSM that delivers 1 instruction per 2 cycles.
//   defined   : 2-entry {inst,pc} FIFO plus an in-flight flag that delivers 1 instruction
//               per cycle.
//
// Ports
//   i_clk, i_rst        clock (rising edge), asynchronous active-low reset
//   i_redirect(_pc)     load PC from i_redirect_pc and flush
//   i_mem_data          BRAM port A read data, one cycle after o_mem_addr
//   o_mem_addr          BRAM port A address (the fetch PC)
//   o_mem_write         BRAM port A write enable, always 0
//   o_inst, o_pc        fetched instruction and its word address
//   o_valid, i_ready    handshake; a transfer happens when o_valid & i_ready

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 10
`endif

module fetch_unit #(
  parameter int unsigned           DATA_WIDTH = `DATA_WIDTH,
  parameter int unsigned           ADDR_WIDTH = `ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_redirect,
  input  logic [ADDR_WIDTH-1:0] i_redirect_pc,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_write,
  output logic [DATA_WIDTH-1:0] o_inst,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic                  o_valid,
  input  logic                  i_ready
);

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;

  assign o_mem_addr  = fetch_pc_q;
  assign o_mem_write = 1'b0;

`ifdef FETCH_PREFETCH_EN

  logic [1:0][DATA_WIDTH-1:0] fifo_inst_q, fifo_inst_d;
  logic [1:0][ADDR_WIDTH-1:0] fifo_pc_q, fifo_pc_d;
  logic                       rd_ptr_q, rd_ptr_d;
  logic                       wr_ptr_q, wr_ptr_d;
  logic [1:0]                 count_q, count_d;
  logic                       inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0]      req_pc_q, req_pc_d;
  logic                       pop, issue;
  logic [2:0]                 occ;

  always_comb begin
    pop   = (count_q != 2'd0) & i_ready;
    // Slots already committed after this cycle's pop. A new read is issued only if its
    // response is guaranteed a free slot.
    occ   = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    issue = occ < 3'd2;

    fifo_inst_d = fifo_inst_q;
    fifo_pc_d   = fifo_pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    inflight_d  = inflight_q;
    req_pc_d    = req_pc_q;
    fetch_pc_d  = fetch_pc_q;

    if (i_redirect) begin
      // Drop the queue and the in-flight response.
      count_d    = 2'd0;
      inflight_d = 1'b0;
      rd_ptr_d   = 1'b0;
      wr_ptr_d   = 1'b0;
      fetch_pc_d = i_redirect_pc;
    end else begin
      if (inflight_q) begin
        fifo_inst_d[wr_ptr_q] = i_mem_data;
        fifo_pc_d[wr_ptr_q]   = req_pc_q;
        wr_ptr_d              = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d    = count_q + 2'(inflight_q) - 2'(pop);
      inflight_d = issue;
      if (issue) begin
        fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(1);
        req_pc_d   = fetch_pc_q;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      fifo_inst_q <= '0;
      fifo_pc_q   <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      inflight_q  <= 1'b0;
      req_pc_q    <= '0;
      fetch_pc_q  <= RESET_PC;
    end else begin
      fifo_inst_q <= fifo_inst_d;
      fifo_pc_q   <= fifo_pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      req_pc_q    <= req_pc_d;
      fetch_pc_q  <= fetch_pc_d;
    end
  end

  assign o_valid = (count_q != 2'd0);
  assign o_inst  = fifo_inst_q[rd_ptr_q];
  assign o_pc    = fifo_pc_q[rd_ptr_q];

`else

  typedef enum logic [1:0] {StIssue, StWait, StHold} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  valid_q, valid_d;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    inst_d     = inst_q;
    pc_d       = pc_q;
    valid_d    = valid_q;

    if (i_redirect) begin
      fetch_pc_d = i_redirect_pc;
      valid_d    = 1'b0;
      state_d    = StIssue;
    end else begin
      unique case (state_q)
        StIssue: state_d = StWait;
        StWait: begin
          inst_d     = i_mem_data;
          pc_d       = fetch_pc_q;
          valid_d    = 1'b1;
          fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(1);
          state_d    = StHold;
        end
        StHold: begin
          // The incremented PC is already on the address bus, so its read was issued this
          // cycle. Its data arrives in the following StWait cycle.
          if (i_ready) begin
            valid_d = 1'b0;
            state_d = StWait;
          end
        end
        default: state_d = StIssue;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q    <= StIssue;
      fetch_pc_q <= RESET_PC;
      inst_q     <= '0;
      pc_q       <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
    end
  end

  assign o_valid = valid_q;
  assign o_inst  = inst_q;
  assign o_pc    = pc_q;

`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit (default build: 1 instruction per 2 cycles).
// It instantiates two DUTs. The main one has RESET_PC=0. The second one has
// RESET_PC=2^ADDR_WIDTH-1, runs with i_ready tied high, and checks PC wrap and cadence.
module tb_fetch_unit;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;

  logic          clk;
  logic          rst;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          ready;
  logic [DW-1:0] mem_data, mem_data_w;
  logic [AW-1:0] mem_addr, mem_addr_w;
  logic          mem_write, mem_write_w;
  logic [DW-1:0] inst, inst_w;
  logic [AW-1:0] pc, pc_w;
  logic          valid, valid_w;
  logic          ready_w;
  logic          redirect_w;
  logic [AW-1:0] redirect_pc_w;

  logic [DW-1:0] mem [256];

  int checks = 0;
  int errors = 0;

  fetch_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_PC(8'h00)) dut (
    .i_clk(clk), .i_rst(rst), .i_redirect(redirect), .i_redirect_pc(redirect_pc),
    .i_mem_data(mem_data), .o_mem_addr(mem_addr), .o_mem_write(mem_write),
    .o_inst(inst), .o_pc(pc), .o_valid(valid), .i_ready(ready)
  );

  fetch_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESET_PC(8'hFF)) dut_w (
    .i_clk(clk), .i_rst(rst), .i_redirect(redirect_w), .i_redirect_pc(redirect_pc_w),
    .i_mem_data(mem_data_w), .o_mem_addr(mem_addr_w), .o_mem_write(mem_write_w),
    .o_inst(inst_w), .o_pc(pc_w), .o_valid(valid_w), .i_ready(ready_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read BRAM models.
  always @(posedge clk) begin
    mem_data   <= mem[mem_addr];
    mem_data_w <= mem[mem_addr_w];
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          rdy;
    bit          redir;
    logic [7:0]  rpc;
    bit          exp_valid;
    logic [7:0]  exp_pc;
  } row_t;

  row_t rows[26];

  logic [AW-1:0] exp_pc;
  logic [AW-1:0] wpc;
  bit            xfer, cur_valid;
  int            gap;

  initial begin
    // Each row applies inputs before an edge and lists the outputs expected after it.
    rows[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    rows[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00};
    rows[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00};
    rows[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00};
    rows[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00};
    rows[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00};
    rows[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h00};
    rows[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    rows[8]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h01};
    rows[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    rows[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h02};
    rows[11] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    rows[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h03};
    rows[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h03};
    rows[14] = '{1'b0, 1'b1, 8'h40, 1'b0, 8'h00};
    rows[15] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
    rows[16] = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h40};
    rows[17] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    rows[18] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h41};
    rows[19] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    rows[20] = '{1'b1, 1'b1, 8'h10, 1'b0, 8'h00};
    rows[21] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    rows[22] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h10};
    rows[23] = '{1'b1, 1'b1, 8'h20, 1'b0, 8'h00};
    rows[24] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
    rows[25] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h20};

    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;
    mem[0] = 32'hAAAA_0001;

    rst           = 1'b0;
    ready         = 1'b1;
    redirect      = 1'b0;
    redirect_pc   = '0;
    ready_w       = 1'b1;
    redirect_w    = 1'b0;
    redirect_pc_w = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_valid", DW'(valid), 0);
    chk("rst_inst", inst, 0);
    chk("rst_pc", DW'(pc), 0);
    chk("rst_mem_write", DW'(mem_write), 0);
    chk("rst_mem_addr", DW'(mem_addr), 0);
    chk("rst_wrap_addr", DW'(mem_addr_w), 32'hFF);

    // Directed table, with wrap/cadence checks on the second DUT.
    rst = 1'b1;
    for (int i = 0; i < 26; i++) begin
      ready       = rows[i].rdy;
      redirect    = rows[i].redir;
      redirect_pc = rows[i].rpc;
      @(negedge clk);
      chk($sformatf("row%0d_valid", i), DW'(valid), DW'(rows[i].exp_valid));
      if (rows[i].exp_valid) begin
        chk($sformatf("row%0d_pc", i), DW'(pc), DW'(rows[i].exp_pc));
        chk($sformatf("row%0d_inst", i), inst, mem[rows[i].exp_pc]);
      end
      chk($sformatf("row%0d_mem_write", i), DW'(mem_write | mem_write_w), 0);
      chk($sformatf("wrap%0d_valid", i), DW'(valid_w), DW'(i % 2));
      if (valid_w) begin
        wpc = AW'(255 + (i - 1) / 2);
        chk($sformatf("wrap%0d_pc", i), DW'(pc_w), DW'(wpc));
        chk($sformatf("wrap%0d_inst", i), inst_w, mem[wpc]);
      end
    end
    redirect = 1'b0;
    ready    = 1'b0;

    // Asynchronous reset while valid, then restart at RESET_PC.
    chk("pre_async_valid", DW'(valid), 1);
    #2 rst = 1'b0;
    #1;
    chk("async_valid", DW'(valid), 0);
    chk("async_pc", DW'(pc), 0);
    chk("async_wrap_valid", DW'(valid_w), 0);
    @(negedge clk);
    rst   = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    chk("restart_v0", DW'(valid), 0);
    @(negedge clk);
    chk("restart_valid", DW'(valid), 1);
    chk("restart_pc", DW'(pc), 0);
    chk("restart_inst", inst, mem[0]);

    // Random phase against a stream-level model of the instructions presented.
    rst = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    @(negedge clk);
    rst    = 1'b1;
    exp_pc = '0;
    gap    = 0;
    for (int n = 0; n < 400; n++) begin
      ready       = 1'($urandom_range(0, 1));
      redirect    = ($urandom_range(0, 9) == 0);
      redirect_pc = AW'($urandom);
      cur_valid   = valid;
      xfer        = valid & ready;
      @(negedge clk);
      if (redirect) exp_pc = redirect_pc;
      else if (xfer) exp_pc = exp_pc + 1'b1;
      if (redirect) chk("rnd_flush", DW'(valid), 0);
      else if (cur_valid && !ready) chk("rnd_hold", DW'(valid), 1);
      if (valid) begin
        chk("rnd_pc", DW'(pc), DW'(exp_pc));
        chk("rnd_inst", inst, mem[exp_pc]);
      end
      if (redirect || xfer) gap = 0;
      if (!valid) gap++;
      else gap = 0;
      chk("rnd_latency", DW'(gap <= 2), 1);
      chk("rnd_mem_write", DW'(mem_write), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage. Owns the program counter, reads instruction words through BRAM port A (synchronous read, 1-cycle latency), and presents them to decode with a valid/ready handshake.
- Sits between the bram instance in core and the downstream decode stage.
- Accepts a redirect (branch/jump) from later stages that flushes everything fetched and restarts at a new PC.

Parameters:
- DATA_WIDTH, `DATA_WIDTH, instruction/memory word width.
- ADDR_WIDTH, `ADDR_WIDTH, word address width; PC is a word address.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-low (0 = in reset).
- i_redirect  in  1  load i_redirect_pc into PC and flush.
- i_redirect_pc  in  ADDR_WIDTH  redirect target.
- i_mem_data  in  DATA_WIDTH  BRAM port A read data.
- o_mem_addr  out  ADDR_WIDTH  BRAM port A address; always equals internal fetch_pc.
- o_mem_write  out  1  BRAM port A write enable; tied 0.
- o_inst  out  DATA_WIDTH  fetched instruction.
- o_pc  out  ADDR_WIDTH  address of o_inst.
- o_valid  out  1  o_inst/o_pc valid.
- i_ready  in  1  decode accepts this cycle; transfer = o_valid & i_ready.

Behaviour:
- Reset (i_rst=0, async):
  - fetch_pc=RESET_PC, state=S_ISSUE.
  - o_valid=0, o_inst=0, o_pc=0, o_mem_write=0.
- BRAM timing: address driven in cycle N gives data on i_mem_data in cycle N+1.
- PC arithmetic: fetch_pc+1 modulo 2^ADDR_WIDTH; 2^ADDR_WIDTH-1 wraps to 0.
- Baseline FSM:
  - S_ISSUE: o_mem_addr=fetch_pc; next S_WAIT.
  - S_WAIT: o_inst<=i_mem_data, o_pc<=fetch_pc, o_valid<=1, fetch_pc<=fetch_pc+1; next S_HOLD.
  - S_HOLD: o_valid=1, o_inst/o_pc stable.
    - i_ready=1: o_valid<=0, next S_WAIT. o_mem_addr already shows the next PC, so the read is issued this cycle.
    - i_ready=0: stay in S_HOLD.
  - Steady-state throughput: 1 instruction per 2 cycles.
- Redirect (highest priority, any state): fetch_pc<=i_redirect_pc, o_valid<=0, state<=S_ISSUE.
  - Any in-flight read is discarded.
  - A transfer in the same cycle as the redirect still counts as accepted.
- First o_valid=1 appears after the 2nd rising edge following reset release or redirect.
- o_valid never drops without a transfer, except on redirect or reset.
- o_mem_write is never 1.

Optional Feature:
- Macro: FETCH_PREFETCH_EN.
- Defined: the FSM is replaced by a 2-entry FIFO of {inst,pc} plus an inflight flag.
  - o_valid = (count!=0); outputs come from the FIFO head.
  - issue = (count + inflight - pop) < 2, where pop = o_valid & i_ready.
  - On issue: inflight<=1, fetch_pc<=fetch_pc+1. Otherwise inflight<=0.
  - If inflight: push {i_mem_data, pc_of_request}.
  - Simultaneous push and pop keeps count unchanged.
  - Redirect: count<=0, inflight<=0, fetch_pc<=i_redirect_pc. The in-flight response is dropped, never pushed.
  - Sustained 1 instruction/cycle with i_ready=1; the FIFO never overflows.
- Undefined: baseline FSM, 1 instruction per 2 cycles.
- Reset values and port list are identical in both modes.

Test Plan:
- Reset, RESET_PC=0, mem[0]=0xAAAA0001, i_ready=1.
  - -> o_mem_write=0 throughout.
  - -> o_valid=1, o_inst=0xAAAA0001, o_pc=0 after 2nd edge post-release.
- Backpressure: i_ready=0 for 5 cycles while o_valid=1.
  - -> o_inst/o_pc unchanged, o_valid stays 1.
  - -> Raising i_ready transfers exactly once, then o_pc=1 appears.
- Redirect to 0x40 while holding pc=3, with i_ready=0.
  - -> o_valid=0 next cycle.
  - -> Next valid is o_pc=0x40, o_inst=mem[0x40]; pc=4 is never presented.
- Wrap: RESET_PC=2^ADDR_WIDTH-1, i_ready=1.
  - -> o_pc sequence is 2^ADDR_WIDTH-1 then 0.
- Throughput: mem[i]=i, i_ready=1, 20 cycles.
  - -> Baseline: one transfer every 2 cycles.
  - -> With FETCH_PREFETCH_EN: pcs 0..7 transferred on edges 2..9, one per cycle, in order.
- Reset mid-operation: assert i_rst=0 asynchronously while o_valid=1.
  - -> o_valid=0 immediately, without waiting for a clock edge.
  - -> After release, fetch restarts at RESET_PC.
